// File: rtl/uart_tx_arbiter.sv
// Round-robin, packet-locked arbiter sharing one uart_tx among NREQ byte-stream requesters.
// Optional stall-release counter enabled by defining UART_ARB_TIMEOUT_EN.
module uart_tx_arbiter #(
  parameter int unsigned NREQ    = 4,
  parameter int unsigned TIMEOUT = 1024
) (
  input  logic              clock,
  input  logic              resetn,
  input  logic [NREQ-1:0]   req_valid_i,
  input  logic [8*NREQ-1:0] req_byte_i,
  input  logic [NREQ-1:0]   req_last_i,
  output logic [NREQ-1:0]   req_ready_o,
  output logic              tx_valid_o,
  output logic [7:0]        tx_byte_o,
  input  logic              tx_dequeue_i,
  output logic [NREQ-1:0]   grant_o,
  output logic              busy_o
);

  localparam int unsigned PtrW = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic [0:0] {StIdle, StLocked} state_e;

  state_e            state_q, state_d;
  logic [NREQ-1:0]   grant_q, grant_d;
  logic [PtrW-1:0]   rr_ptr_q, rr_ptr_d;

  logic [PtrW-1:0]   grant_idx;
  logic [PtrW-1:0]   next_ptr;
  logic [PtrW-1:0]   pick_idx;
  logic [PtrW-1:0]   cand_idx;
  int unsigned       cand;
  logic              pick_found;
  logic              granted_last;
  logic              accept;
  logic              timeout_hit;
  logic              release_pkt;

  always_comb begin
    grant_idx = '0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      if (grant_q[k]) grant_idx = PtrW'(k);
    end
  end

  assign next_ptr = (grant_idx == PtrW'(NREQ - 1)) ? '0 : grant_idx + PtrW'(1);

  // First valid requester at or above rr_ptr, wrapping around.
  always_comb begin
    pick_found = 1'b0;
    pick_idx   = '0;
    cand       = 0;
    cand_idx   = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      cand     = (32'(rr_ptr_q) + i) % NREQ;
      cand_idx = PtrW'(cand);
      if (!pick_found && req_valid_i[cand_idx]) begin
        pick_found = 1'b1;
        pick_idx   = cand_idx;
      end
    end
  end

  assign tx_valid_o   = (state_q == StLocked) && |(grant_q & req_valid_i);
  assign granted_last = |(grant_q & req_last_i);
  assign accept       = tx_valid_o & tx_dequeue_i;
  assign req_ready_o  = accept ? grant_q : '0;
  assign grant_o      = grant_q;
  assign busy_o       = (state_q == StLocked);

  always_comb begin
    tx_byte_o = 8'h00;
    for (int unsigned k = 0; k < NREQ; k++) begin
      if (tx_valid_o && grant_q[k]) tx_byte_o = req_byte_i[8*k +: 8];
    end
  end

`ifdef UART_ARB_TIMEOUT_EN
  logic [15:0] stall_cnt_q, stall_cnt_d;

  // Counts stalled locked cycles; the TIMEOUT-th one releases the grant.
  always_comb begin
    stall_cnt_d = '0;
    timeout_hit = 1'b0;
    if (state_q == StLocked && !tx_valid_o) begin
      if (stall_cnt_q == 16'(TIMEOUT - 1)) begin
        timeout_hit = 1'b1;
      end else begin
        stall_cnt_d = stall_cnt_q + 16'd1;
      end
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      stall_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
    end
  end
`else
  logic unused_timeout;
  assign unused_timeout = ^16'(TIMEOUT);
  assign timeout_hit    = 1'b0;
`endif

  assign release_pkt = (accept && granted_last) || timeout_hit;

  always_comb begin
    state_d  = state_q;
    grant_d  = grant_q;
    rr_ptr_d = rr_ptr_q;
    unique case (state_q)
      StIdle: begin
        if (pick_found) begin
          state_d           = StLocked;
          grant_d           = '0;
          grant_d[pick_idx] = 1'b1;
        end
      end
      StLocked: begin
        if (release_pkt) begin
          state_d  = StIdle;
          grant_d  = '0;
          rr_ptr_d = next_ptr;
        end
      end
      default: begin
        state_d = StIdle;
        grant_d = '0;
      end
    endcase
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q  <= StIdle;
      grant_q  <= '0;
      rr_ptr_q <= '0;
    end else begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      rr_ptr_q <= rr_ptr_d;
    end
  end

endmodule

// File: doc/uart_tx_arbiter.md
# uart_tx_arbiter

Shares a single `uart_tx` transmitter between `NREQ` byte-stream requesters on the same clock. Grants are round-robin and packet-locked: once granted, a requester owns the transmitter until the byte flagged `last` is dequeued, so multi-byte messages are never interleaved. Sits between the requester-side logic (console, debug monitor, loopback path) and the `uart_tx` instance, driving its `tx_i`/`tx_byte_i` and consuming its `tx_dequeue_o`.

## Interface
- `NREQ`, 4: number of requesters, 2..8.
- `TIMEOUT`, 1024: idle-cycle limit for a stalled locked grant (used only with `UART_ARB_TIMEOUT_EN`), 1..65535.

Ports:
- `clock` in 1: system clock.
- `resetn` in 1: asynchronous, active-low reset.
- `req_valid_i` in NREQ: requester k has a byte pending.
- `req_byte_i` in 8*NREQ: byte of requester k at bits [8k+7:8k].
- `req_last_i` in NREQ: byte of requester k is the final byte of its packet.
- `req_ready_o` out NREQ: one-cycle pulse, byte of requester k accepted.
- `tx_valid_o` out 1: to `uart_tx.tx_i`.
- `tx_byte_o` out 8: to `uart_tx.tx_byte_i`.
- `tx_dequeue_i` in 1: from `uart_tx.tx_dequeue_o`, one-cycle accept pulse.
- `grant_o` out NREQ: one-hot current owner, all-zero when idle.
- `busy_o` out 1: a grant is held.

## Operation
- States: IDLE, LOCKED. Registers: `state`, `grant` (one-hot), `rr_ptr` (index of highest-priority requester, $clog2(NREQ) bits).
- IDLE: if any `req_valid_i` set, pick the first set bit searching upward from `rr_ptr` with wrap; register it into `grant`, go LOCKED. No valid: stay IDLE.
- LOCKED: `tx_valid_o = |(grant & req_valid_i)`; `tx_byte_o` = granted requester's byte; all other requesters are ignored.
- `req_ready_o = grant & {NREQ{tx_dequeue_i}}` when LOCKED, else zero.
- Dequeue with granted `req_last_i` = 1: clear `grant`, set `rr_ptr` to (granted index + 1) mod NREQ, go IDLE.
- Dequeue with `last` = 0: stay LOCKED, same owner.
- `tx_dequeue_i` in IDLE or with `tx_valid_o` = 0: ignored, no state change.
- Requester protocol: byte and `last` held stable while valid until ready; valid may drop only between bytes.
- `rr_ptr` advances only on packet completion (or timeout release); fairness is per packet, not per byte.

## Timing
- Reset (async assert): `state`=IDLE, `grant`=0, `rr_ptr`=0; hence `tx_valid_o`=0, `tx_byte_o`=0, `req_ready_o`=0, `grant_o`=0, `busy_o`=0.
- Reset mid-packet: grant dropped immediately, packet abandoned; requester restarts it after reset.
- Arbitration latency: valid sampled in IDLE at cycle N -> `grant_o`/`tx_valid_o` high at N+1.
- Pass-through in LOCKED is combinational: `tx_valid_o`, `tx_byte_o`, `req_ready_o` change in the same cycle as their inputs.
- Packet release: last-byte dequeue at N -> IDLE at N+1, next grant visible at N+2 (one bubble cycle, always).
- `tx_byte_o` is 0 whenever `tx_valid_o` is 0.

## Configuration
- `UART_ARB_TIMEOUT_EN` defined: 16-bit counter increments each LOCKED cycle with `tx_valid_o` = 0, clears on any cycle with `tx_valid_o` = 1; reaching `TIMEOUT` releases the grant exactly as a `last` dequeue does (IDLE next cycle, `rr_ptr` advanced), without a `req_ready_o` pulse.
- Not defined: no counter; a locked owner holds the transmitter indefinitely until its `last` byte.

## Test plan
- Single requester 0 sends 3 bytes 0x41,0x42,0x43 (last on 0x43), dequeue every 10 cycles -> `tx_byte_o` sequence 0x41,0x42,0x43, three `req_ready_o[0]` pulses, `busy_o` low 1 cycle after third dequeue.
- Requesters 0..3 all valid, 1-byte packets, from reset -> grant order 0,1,2,3,0; one idle cycle between grants.
- Requester 1 sends 2-byte packet while requester 2 holds valid -> no byte of 2 appears between the two bytes of 1; 2 granted 2 cycles after 1's last dequeue.
- `resetn` asserted while LOCKED with byte pending -> `tx_valid_o`, `grant_o`, `busy_o` 0 same cycle; after release requester 0 granted first.
- With `UART_ARB_TIMEOUT_EN`, `TIMEOUT`=8: requester 3 sends non-last byte then drops valid -> grant released after 8 stalled cycles, requester 0 (valid) granted next; without macro, grant held 100+ cycles.
